button_pulse_gen: RTL and testbench

Conditions a raw push-button into a clean single-cycle advance pulse for the LED colour-cycling stage. The block sits directly upstream of the LED interface and drives its `signal` input.

---
 rtl/button_pulse_gen_pkg.sv | 25 ++
 rtl/button_pulse_gen_sync_2ff.sv | 23 ++
 rtl/button_pulse_gen.sv | 128 ++++++++++++
 tb/tb_button_pulse_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/button_pulse_gen_pkg.sv
// rtl/button_pulse_gen_pkg.sv - clock constants, ms-to-cycle helper and FSM state type for button conditioning
package button_pulse_gen_pkg;

    localparam int CLK_FREQ_HZ   = 27_000_000;
    localparam int CYCLES_PER_MS = CLK_FREQ_HZ / 1000;

    function automatic int ms_to_cycles(input int ms);
        return ms * CYCLES_PER_MS;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_DB_RELEASE = 3'd4
    } btn_state_t;

endpackage

// File: rtl/button_pulse_gen_sync_2ff.sv
// rtl/button_pulse_gen_sync_2ff.sv - two-flop synchronizer for asynchronous pins, reset to a chosen idle level
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - debounced push-button to single-cycle advance pulse with optional hold auto-repeat
module button_pulse_gen
    import button_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = ms_to_cycles(10),
    parameter bit REPEAT_EN            = 1'b1,
    parameter int REPEAT_DELAY_CYCLES  = ms_to_cycles(500),
    parameter int REPEAT_PERIOD_CYCLES = ms_to_cycles(200),
    parameter bit BUTTON_ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_in,
    output logic       pulse,
    output logic       pressed,
    output logic [2:0] state_dbg
);

    localparam int MAX_CYCLES = max3(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES), 2, 2);
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DB_LAST     = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t DELAY_LAST  = cnt_t'(REPEAT_DELAY_CYCLES - 1);
    localparam cnt_t PERIOD_LAST = cnt_t'(REPEAT_PERIOD_CYCLES - 1);

    logic       sync_q;
    logic       btn_s;
    btn_state_t state, next_state;
    cnt_t       cnt, next_cnt;
    logic       next_pulse;

    // Reset value is the raw released level so a reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (BUTTON_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button_in),
        .q     (sync_q)
    );

    assign btn_s = sync_q ^ BUTTON_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            pulse <= next_pulse;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                next_cnt = '0;
                if (btn_s) next_state = ST_DB_PRESS;
            end
            ST_DB_PRESS: begin
                if (!btn_s) begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end else if (cnt == DB_LAST) begin
                    next_state = ST_HELD;
                    next_cnt   = '0;
                    next_pulse = 1'b1;
                end else begin
                    next_cnt = cnt + cnt_t'(1);
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    next_state = ST_DB_RELEASE;
                    next_cnt   = '0;
                end else if (REPEAT_EN) begin
                    if (cnt == DELAY_LAST) begin
                        next_state = ST_REPEAT;
                        next_cnt   = '0;
                        next_pulse = 1'b1;
                    end else begin
                        next_cnt = cnt + cnt_t'(1);
                    end
                end else begin
                    next_cnt = '0;
                end
            end
            ST_REPEAT: begin
                // A release on the firing edge wins; the pulse is dropped.
                if (!btn_s) begin
                    next_state = ST_DB_RELEASE;
                    next_cnt   = '0;
                end else if (cnt == PERIOD_LAST) begin
                    next_cnt   = '0;
                    next_pulse = 1'b1;
                end else begin
                    next_cnt = cnt + cnt_t'(1);
                end
            end
            ST_DB_RELEASE: begin
                if (btn_s) begin
                    next_state = ST_HELD;
                    next_cnt   = '0;
                end else if (cnt == DB_LAST) begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + cnt_t'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign pressed   = (state == ST_HELD) || (state == ST_REPEAT) || (state == ST_DB_RELEASE);
    assign state_dbg = state;

endmodule

// File: tb/tb_button_pulse_gen.sv
// tb/tb_button_pulse_gen.sv - directed vector bench for button_pulse_gen with repeat enabled and disabled
module tb_button_pulse_gen;

    logic       clk;
    logic       reset;
    logic       button_in;
    logic       pulse, pressed;
    logic [2:0] state_dbg;
    logic       pulse_nr, pressed_nr;
    logic [2:0] state_dbg_nr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       btn;
        logic       exp_pulse;
        logic       exp_pressed;
        logic [2:0] exp_state;
    } vec_t;

    vec_t vecs [16];

    button_pulse_gen #(
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_EN            (1'b1),
        .REPEAT_DELAY_CYCLES  (10),
        .REPEAT_PERIOD_CYCLES (5),
        .BUTTON_ACTIVE_LOW    (1'b1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .button_in (button_in),
        .pulse     (pulse),
        .pressed   (pressed),
        .state_dbg (state_dbg)
    );

    button_pulse_gen #(
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_EN            (1'b0),
        .REPEAT_DELAY_CYCLES  (10),
        .REPEAT_PERIOD_CYCLES (5),
        .BUTTON_ACTIVE_LOW    (1'b1)
    ) u_dut_nr (
        .clk       (clk),
        .reset     (reset),
        .button_in (button_in),
        .pulse     (pulse_nr),
        .pressed   (pressed_nr),
        .state_dbg (state_dbg_nr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic r, input logic b);
        reset     = r;
        button_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input int idx,
                             input logic ep, input logic epr, input logic [2:0] es);
        n_vec++;
        if ({pulse, pressed, state_dbg} !== {ep, epr, es}) begin
            n_err++;
            $display("FAIL %s[%0d]: got pulse=%b pressed=%b state=%0d, want pulse=%b pressed=%b state=%0d",
                     name, idx, pulse, pressed, state_dbg, ep, epr, es);
        end
    endtask

    task automatic check_val(input string name, input int idx,
                             input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, want %0d", name, idx, got, exp);
        end
    endtask

    initial begin
        int cnt_rep, cnt_nr;
        logic exp_p;

        reset     = 1'b1;
        button_in = 1'b1;

        // Press/release table: 8 pressed samples then released, one pulse after E7
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 3'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 3'd2};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'd2};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 3'd4};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 3'd4};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 3'd4};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 3'd4};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 3'd0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 3'd0};

        // Reset state, including reset holding off a pressed pin
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check_all("reset_rel", i, 1'b0, 1'b0, 3'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            check_all("reset_prs", i, 1'b0, 1'b0, 3'd0);
        end
        step(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1);
            check_all("idle_rel", i, 1'b0, 1'b0, 3'd0);
        end

        for (int i = 0; i < 16; i++) begin
            step(1'b0, vecs[i].btn);
            check_all("press_tbl", i, vecs[i].exp_pulse, vecs[i].exp_pressed, vecs[i].exp_state);
        end

        // Bounce: never five consecutive pressed samples
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, (k == 3) ? 1'b1 : 1'b0);
                check_val("bounce", r * 4 + k, {30'd0, pulse, pressed}, 32'd0);
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        check_val("bounce_idle", 0, state_dbg, 0);

        // Hold 40 cycles on both variants
        cnt_rep = 0;
        cnt_nr  = 0;
        for (int e = 1; e <= 40; e++) begin
            step(1'b0, 1'b0);
            exp_p = (e == 7 || e == 17 || e == 22 || e == 27 || e == 32 || e == 37);
            check_val("rep_pulse", e, pulse, exp_p);
            check_val("norep_pulse", e, pulse_nr, (e == 7));
            cnt_rep += pulse;
            cnt_nr  += pulse_nr;
        end
        check_val("rep_count", 0, cnt_rep, 6);
        check_val("norep_count", 0, cnt_nr, 1);
        check_val("norep_state", 0, state_dbg_nr, 2);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        check_val("rep_idle", 0, state_dbg, 0);
        check_val("norep_idle", 0, state_dbg_nr, 0);

        // Release glitch while HELD restarts the repeat delay
        for (int e = 1; e <= 25; e++) begin
            step(1'b0, (e == 9 || e == 10) ? 1'b1 : 1'b0);
            check_val("glitch_pulse", e, pulse, (e == 7 || e == 23));
            check_val("glitch_pressed", e, pressed, (e >= 7));
            if (e == 11) check_val("glitch_dbrel", e, state_dbg, 4);
            if (e == 13) check_val("glitch_held", e, state_dbg, 2);
            if (e == 23) check_val("glitch_repeat", e, state_dbg, 3);
        end

        // Reset mid-REPEAT with the button still held
        step(1'b1, 1'b0);
        check_all("mid_reset", 0, 1'b0, 1'b0, 3'd0);
        check_val("mid_reset_nr", 0, state_dbg_nr, 0);
        for (int n = 1; n <= 10; n++) begin
            step(1'b0, 1'b0);
            check_val("post_reset_pulse", n, pulse, (n == 7));
            check_val("post_reset_pressed", n, pressed, (n >= 7));
            if (n == 2) check_val("post_reset_idle", n, state_dbg, 0);
            if (n == 3) check_val("post_reset_dbp", n, state_dbg, 1);
            if (n == 7) check_val("post_reset_held", n, state_dbg, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
